// File: rtl/up_dac_obuf.sv
// up_dac_obuf -- processor-bus programmable DAC waveform buffer.
//
// Software loads samples into an internal sample RAM over a req/ack register
// bus, programs playback length (LEN) and sample period (DIV), then sets RUN
// to stream RAM[0..LEN] to the DAC data port in a loop (or once with ONESHOT).
//
// Ports:
//   up_clk, up_rst        single clock, synchronous active-high reset
//   up_wreq/up_waddr/up_wdata/up_wack   write channel (level req, 1-cycle ack)
//   up_rreq/up_raddr/up_rdata/up_rack   read channel  (level req, 1-cycle ack)
//   dac_async_trig_i      external start trigger (asynchronous)
//   dac_odat_o            registered DAC sample
//   dac_refclk_o          one-cycle strobe per dac_odat_o update
//
// Register map (addr MSB = 0): 0 CTRL {TRIG_MODE,ONESHOT,RUN}, 1 LEN,
// 2 DIV, 3 STATUS {ptr[31:16], armed, playing}. addr MSB = 1 selects the RAM.
//
// Build option: define ASYNC_TRIG_EN to enable the synchronized external
// trigger and the CTRL.TRIG_MODE bit; otherwise the trigger input is ignored.

module up_dac_obuf #(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DACBUF_SIZE   = 8,
  parameter int DACDAT_WIDTH  = 14
) (
  input  logic                     up_clk,
  input  logic                     up_rst,
  input  logic                     up_wreq,
  input  logic [ADDRESS_WIDTH-1:0] up_waddr,
  input  logic [31:0]              up_wdata,
  output logic                     up_wack,
  input  logic                     up_rreq,
  input  logic [ADDRESS_WIDTH-1:0] up_raddr,
  output logic [31:0]              up_rdata,
  output logic                     up_rack,
  input  logic                     dac_async_trig_i,
  output logic [DACDAT_WIDTH-1:0]  dac_odat_o,
  output logic                     dac_refclk_o
);

  localparam int DEPTH = 1 << DACBUF_SIZE;
  localparam int OFS_W = ADDRESS_WIDTH - 1;
  localparam logic [OFS_W-1:0] A_CTRL   = OFS_W'(0);
  localparam logic [OFS_W-1:0] A_LEN    = OFS_W'(1);
  localparam logic [OFS_W-1:0] A_DIV    = OFS_W'(2);
  localparam logic [OFS_W-1:0] A_STATUS = OFS_W'(3);

`ifdef ASYNC_TRIG_EN
  localparam logic TRIG_ALLOWED = 1'b1;
`else
  localparam logic TRIG_ALLOWED = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_PLAY} state_t;

  logic [DACDAT_WIDTH-1:0] mem [DEPTH];

  state_t                  state_q, state_d;
  logic                    run_q, run_d;
  logic                    oneshot_q, oneshot_d;
  logic                    trigm_q, trigm_d;
  logic [DACBUF_SIZE-1:0]  len_q, len_d;
  logic [15:0]             div_q, div_d;
  logic [DACBUF_SIZE-1:0]  ptr_q, ptr_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [DACDAT_WIDTH-1:0] odat_q, odat_d;
  logic                    refclk_q, refclk_d;
  logic                    wack_q, wack_d;
  logic                    rack_q, rack_d;
  logic [31:0]             rdata_q, rdata_d;

  logic                    wr_acc, rd_acc, wr_ram, wr_reg;
  logic [31:0]             rd_val;
  logic                    trig_rise;

  // LEN holds the last played index; larger values clamp to the last RAM entry.
  function automatic logic [DACBUF_SIZE-1:0] sat_len(input logic [31:0] v);
    if (v > 32'(DEPTH - 1)) return '1;
    return v[DACBUF_SIZE-1:0];
  endfunction

  // A request is taken only while its ack is low, so a held request is not
  // accepted twice.
  assign wr_acc = up_wreq & ~wack_q;
  assign rd_acc = up_rreq & ~rack_q;
  assign wr_ram = wr_acc & up_waddr[ADDRESS_WIDTH-1];
  assign wr_reg = wr_acc & ~up_waddr[ADDRESS_WIDTH-1];

`ifdef ASYNC_TRIG_EN
  logic trig_meta_q, trig_sync_q, trig_prev_q;

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      trig_meta_q <= 1'b0;
      trig_sync_q <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      trig_meta_q <= dac_async_trig_i;
      trig_sync_q <= trig_meta_q;
      trig_prev_q <= trig_sync_q;
    end
  end

  assign trig_rise = trig_sync_q & ~trig_prev_q;
`else
  logic unused_trig;
  assign unused_trig = dac_async_trig_i;
  assign trig_rise   = 1'b0;
`endif

  always_ff @(posedge up_clk) begin
    if (wr_ram) mem[up_waddr[DACBUF_SIZE-1:0]] <= up_wdata[DACDAT_WIDTH-1:0];
  end

  always_comb begin
    rd_val = 32'd0;
    if (up_raddr[ADDRESS_WIDTH-1]) begin
      rd_val = 32'(mem[up_raddr[DACBUF_SIZE-1:0]]);
    end else begin
      case (up_raddr[OFS_W-1:0])
        A_CTRL:   rd_val = {29'd0, trigm_q, oneshot_q, run_q};
        A_LEN:    rd_val = 32'(len_q);
        A_DIV:    rd_val = 32'(div_q);
        A_STATUS: rd_val = (32'(ptr_q) << 16) |
                           {30'd0, state_q == S_ARMED, state_q == S_PLAY};
        default:  rd_val = 32'd0;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    oneshot_d = oneshot_q;
    trigm_d   = trigm_q;
    len_d     = len_q;
    div_d     = div_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    odat_d    = odat_q;
    refclk_d  = 1'b0;
    wack_d    = wr_acc;
    rack_d    = rd_acc;
    rdata_d   = rd_acc ? rd_val : 32'd0;

    case (state_q)
      S_ARMED: begin
        if (trig_rise) begin
          state_d = S_PLAY;
          ptr_d   = '0;
          cnt_d   = '0;
        end
      end
      S_PLAY: begin
        // '>=' keeps the divider sane when DIV is lowered below the count.
        if (cnt_q >= div_q) begin
          odat_d   = mem[ptr_q];
          refclk_d = 1'b1;
          cnt_d    = '0;
          // '>=' so a pointer already past a shortened LEN wraps next time.
          if (ptr_q >= len_q) begin
            ptr_d = '0;
            if (oneshot_q) begin
              // A finished one-shot leaves CTRL idle so software sees 0.
              state_d   = S_IDLE;
              run_d     = 1'b0;
              oneshot_d = 1'b0;
            end
          end else begin
            ptr_d = ptr_q + DACBUF_SIZE'(1);
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: ;
    endcase

    // Register writes override the playback engine in the same cycle.
    if (wr_reg) begin
      case (up_waddr[OFS_W-1:0])
        A_CTRL: begin
          run_d     = up_wdata[0];
          oneshot_d = up_wdata[1];
          trigm_d   = up_wdata[2] & TRIG_ALLOWED;
          if (!up_wdata[0]) begin
            state_d  = S_IDLE;
            ptr_d    = '0;
            cnt_d    = '0;
            odat_d   = '0;
            refclk_d = 1'b0;
          end else if (!run_q) begin
            state_d = (up_wdata[2] & TRIG_ALLOWED) ? S_ARMED : S_PLAY;
            ptr_d   = '0;
            cnt_d   = '0;
          end
        end
        A_LEN:   len_d = sat_len(up_wdata);
        A_DIV:   div_d = up_wdata[15:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge up_clk) begin
    if (up_rst) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      oneshot_q <= 1'b0;
      trigm_q   <= 1'b0;
      len_q     <= '0;
      div_q     <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      odat_q    <= '0;
      refclk_q  <= 1'b0;
      wack_q    <= 1'b0;
      rack_q    <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      oneshot_q <= oneshot_d;
      trigm_q   <= trigm_d;
      len_q     <= len_d;
      div_q     <= div_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      odat_q    <= odat_d;
      refclk_q  <= refclk_d;
      wack_q    <= wack_d;
      rack_q    <= rack_d;
      rdata_q   <= rdata_d;
    end
  end

  assign up_wack      = wack_q;
  assign up_rack      = rack_q;
  assign up_rdata     = rdata_q;
  assign dac_odat_o   = odat_q;
  assign dac_refclk_o = refclk_q;

endmodule

// File: tb/tb_up_dac_obuf.sv
// tb_up_dac_obuf -- directed self-checking bench for up_dac_obuf
// (default parameters: 12-bit address, 256-entry RAM, 14-bit samples).

module tb_up_dac_obuf;

  logic        up_clk = 1'b0;
  logic        up_rst = 1'b1;
  logic        up_wreq = 1'b0;
  logic [11:0] up_waddr = '0;
  logic [31:0] up_wdata = '0;
  logic        up_wack;
  logic        up_rreq = 1'b0;
  logic [11:0] up_raddr = '0;
  logic [31:0] up_rdata;
  logic        up_rack;
  logic        dac_async_trig_i = 1'b0;
  logic [13:0] dac_odat_o;
  logic        dac_refclk_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 up_clk = ~up_clk;

  up_dac_obuf dut (
    .up_clk          (up_clk),
    .up_rst          (up_rst),
    .up_wreq         (up_wreq),
    .up_waddr        (up_waddr),
    .up_wdata        (up_wdata),
    .up_wack         (up_wack),
    .up_rreq         (up_rreq),
    .up_raddr        (up_raddr),
    .up_rdata        (up_rdata),
    .up_rack         (up_rack),
    .dac_async_trig_i(dac_async_trig_i),
    .dac_odat_o      (dac_odat_o),
    .dac_refclk_o    (dac_refclk_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns #1 after the edge at which up_wack is seen high.
  task automatic bus_write(input logic [11:0] a, input logic [31:0] d, output int lat);
    @(posedge up_clk); #1;
    up_wreq = 1'b1; up_waddr = a; up_wdata = d;
    lat = 0;
    do begin
      @(posedge up_clk); #1;
      lat++;
    end while (!up_wack && lat < 8);
    up_wreq = 1'b0;
    if (!up_wack) check("wack_timeout", {31'd0, up_wack}, 32'd1);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    int lat;
    bus_write(a, d, lat);
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    int lat;
    @(posedge up_clk); #1;
    up_rreq = 1'b1; up_raddr = a;
    lat = 0;
    do begin
      @(posedge up_clk); #1;
      lat++;
    end while (!up_rack && lat < 8);
    up_rreq = 1'b0;
    d = up_rdata;
    if (!up_rack) check("rack_timeout", {31'd0, up_rack}, 32'd1);
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [31:0] d;

    // Reset state
    repeat (3) @(posedge up_clk);
    #1;
    check("rst_wack",  {31'd0, up_wack}, 32'd0);
    check("rst_rack",  {31'd0, up_rack}, 32'd0);
    check("rst_rdata", up_rdata, 32'd0);
    check("rst_odat",  {18'd0, dac_odat_o}, 32'd0);
    check("rst_strb",  {31'd0, dac_refclk_o}, 32'd0);
    up_rst = 1'b0;
    rd_chk("rst_ctrl", 12'h000, 32'd0);
    rd_chk("rst_len",  12'h001, 32'd0);
    rd_chk("rst_div",  12'h002, 32'd0);

    // Write handshake timing and readback
    bus_write(12'h001, 32'd30, lat);
    check("wack_latency", lat, 32'd1);
    @(posedge up_clk); #1;
    check("wack_single", {31'd0, up_wack}, 32'd0);
    rd_chk("len_rb", 12'h001, 32'd30);
    wr(12'h001, 32'd300);
    rd_chk("len_sat", 12'h001, 32'd255);
    wr(12'h001, 32'd30);

    // Unmapped addresses
    wr(12'h004, 32'hFFFF_FFFF);
    rd_chk("unmap_rd", 12'h004, 32'd0);
    rd_chk("unmap_7f", 12'h07F, 32'd0);
    rd_chk("unmap_len", 12'h001, 32'd30);

    // RAM aliasing: offsets 0..1023 fold onto 256 entries
    for (int i = 0; i < 1024; i++) wr(12'h800 + 12'(i), 32'(i));
    rd_chk("ram_alias_805", 12'h805, 32'd773);
    rd_chk("ram_alias_8ff", 12'h8FF, 32'd1023);
    wr(12'h810, 32'hFFFF_C00A);
    rd_chk("ram_trunc", 12'h810, 32'h0000_000A);

    // Simultaneous read and write
    wr(12'h002, 32'd9);
    @(posedge up_clk); #1;
    up_wreq = 1'b1; up_waddr = 12'h001; up_wdata = 32'd7;
    up_rreq = 1'b1; up_raddr = 12'h002;
    @(posedge up_clk); #1;
    up_wreq = 1'b0; up_rreq = 1'b0;
    check("sim_wack",  {31'd0, up_wack}, 32'd1);
    check("sim_rack",  {31'd0, up_rack}, 32'd1);
    check("sim_rdata", up_rdata, 32'd9);
    rd_chk("sim_len", 12'h001, 32'd7);

    // Looped playback, one sample per cycle
    for (int i = 0; i < 256; i++) wr(12'h800 + 12'(i), 32'(i));
    wr(12'h001, 32'd30);
    wr(12'h002, 32'd0);
    wr(12'h000, 32'd1);
    for (int k = 0; k < 40; k++) begin
      @(posedge up_clk); #1;
      check("play_dat",  {18'd0, dac_odat_o}, 32'(k % 31));
      check("play_strb", {31'd0, dac_refclk_o}, 32'd1);
    end
    rd(12'h003, d);
    check("status_play", d & 32'h3, 32'd1);

    // Stop mid-playback
    wr(12'h000, 32'd0);
    check("stop_odat", {18'd0, dac_odat_o}, 32'd0);
    check("stop_strb", {31'd0, dac_refclk_o}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(posedge up_clk); #1;
      check("stop_quiet", {31'd0, dac_refclk_o}, 32'd0);
    end
    rd_chk("stop_status", 12'h003, 32'd0);

    // Divided playback: strobe every 4 cycles, 0,1,2,0,...
    wr(12'h002, 32'd3);
    wr(12'h001, 32'd2);
    wr(12'h000, 32'd1);
    for (int c = 1; c <= 16; c++) begin
      @(posedge up_clk); #1;
      check("div_strb", {31'd0, dac_refclk_o}, {31'd0, (c % 4) == 0});
      if ((c % 4) == 0) check("div_dat", {18'd0, dac_odat_o}, 32'(((c / 4) - 1) % 3));
    end
    wr(12'h000, 32'd0);

    // One-shot: 0,1,2 then stop with CTRL cleared
    wr(12'h000, 32'd3);
    for (int c = 1; c <= 24; c++) begin
      @(posedge up_clk); #1;
      check("os_strb", {31'd0, dac_refclk_o}, {31'd0, (c % 4) == 0 && c <= 12});
      if ((c % 4) == 0 && c <= 12) check("os_dat", {18'd0, dac_odat_o}, 32'((c / 4) - 1));
    end
    check("os_hold", {18'd0, dac_odat_o}, 32'd2);
    rd_chk("os_ctrl", 12'h000, 32'd0);
    rd_chk("os_status", 12'h003, 32'd0);

`ifdef ASYNC_TRIG_EN
    // Triggered start
    wr(12'h800, 32'h123);
    wr(12'h001, 32'd0);
    wr(12'h002, 32'd0);
    wr(12'h000, 32'd5);
    rd_chk("trig_ctrl", 12'h000, 32'd5);
    rd_chk("trig_armed", 12'h003, 32'd2);
    for (int k = 0; k < 6; k++) begin
      @(posedge up_clk); #1;
      check("trig_wait", {31'd0, dac_refclk_o}, 32'd0);
    end
    dac_async_trig_i = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(posedge up_clk); #1;
      check("trig_strb", {31'd0, dac_refclk_o}, {31'd0, c >= 4});
      if (c >= 4) check("trig_dat", {18'd0, dac_odat_o}, 32'h123);
    end
    dac_async_trig_i = 1'b0;
    wr(12'h000, 32'd0);
`else
    // Without the trigger option TRIG_MODE is not writable and RUN starts at once
    wr(12'h000, 32'd5);
    rd_chk("nt_ctrl", 12'h000, 32'd1);
    rd(12'h003, d);
    check("nt_play", d & 32'h3, 32'd1);
    wr(12'h000, 32'd0);
`endif

    // Reset during playback
    wr(12'h002, 32'd0);
    wr(12'h001, 32'd5);
    wr(12'h000, 32'd1);
    repeat (3) @(posedge up_clk);
    #1;
    up_rst = 1'b1;
    @(posedge up_clk); #1;
    check("mrst_odat", {18'd0, dac_odat_o}, 32'd0);
    check("mrst_strb", {31'd0, dac_refclk_o}, 32'd0);
    up_rst = 1'b0;
    rd_chk("mrst_ctrl", 12'h000, 32'd0);
    rd_chk("mrst_len",  12'h001, 32'd0);
    rd_chk("mrst_status", 12'h003, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_dac_obuf.md
Name: up_dac_obuf

Overview:
Processor-bus (up_*) programmable DAC waveform buffer. Software loads samples into an on-chip sample RAM through a simple request/acknowledge register bus, sets playback length and rate, then enables looped playback. Samples stream to a parallel DAC data port with a per-sample strobe. Sits between the CPU register interconnect and the DAC front-end; single clock domain.

Parameters:
ADDRESS_WIDTH, 12, width of up_waddr/up_raddr; addr[ADDRESS_WIDTH-1]=1 selects the sample RAM.
DACBUF_SIZE, 8, log2 of sample RAM depth (default 256 entries).
DACDAT_WIDTH, 14, DAC sample width.

Ports:
up_clk  in  1  single clock for bus, RAM and DAC output.
up_rst  in  1  synchronous active-high reset.
up_wreq  in  1  write request; level, held by master until up_wack seen.
up_waddr  in  ADDRESS_WIDTH  write address.
up_wdata  in  32  write data.
up_wack  out  1  write acknowledge, one-cycle pulse.
up_rreq  in  1  read request; level, held until up_rack.
up_raddr  in  ADDRESS_WIDTH  read address.
up_rdata  out  32  read data, valid while up_rack=1.
up_rack  out  1  read acknowledge, one-cycle pulse.
dac_async_trig_i  in  1  external start trigger (asynchronous).
dac_odat_o  out  DACDAT_WIDTH  DAC sample output, registered.
dac_refclk_o  out  1  sample strobe; one-cycle pulse on each dac_odat_o update.

Behaviour:
- Reset (up_rst=1 at clock edge): up_wack=0, up_rack=0, up_rdata=0, dac_odat_o=0, dac_refclk_o=0; CTRL=0, LEN=0, DIV=0, read pointer=0, divider counter=0, trigger sync flops=0. RAM contents not cleared.
- Write handshake: a write is accepted in a cycle with up_wreq=1 and up_wack=0; up_wack=1 in the following cycle for exactly one cycle; a request still high while up_wack=1 is not re-accepted. Reads identical using up_rreq/up_rack; up_rdata registered with up_rack, 0 otherwise. Simultaneous read and write are both served independently.
- Register map (addr[ADDRESS_WIDTH-1]=0): 0x000 CTRL (bit0 RUN, bit1 ONESHOT, bit2 TRIG_MODE); 0x001 LEN = index of last sample played (bits DACBUF_SIZE-1:0; stored value saturates at 2^DACBUF_SIZE-1); 0x002 DIV = sample period minus 1 in up_clk cycles (16 bits); 0x003 STATUS read-only (bit0 playing, bit1 armed, bits 16+ = current read pointer). Unmapped addresses: writes acked and ignored, reads acked returning 0.
- RAM (addr[ADDRESS_WIDTH-1]=1): entry index = addr[DACBUF_SIZE-1:0] (upper offset bits ignored; aliasing wraps); stores up_wdata[DACDAT_WIDTH-1:0]; readable, zero-extended to 32 bits. Writes allowed during playback; take effect when that index is next read.
- Playback: RUN 0->1 (TRIG_MODE=0) starts: pointer=0, divider counter=0. Each time counter reaches DIV: RAM[pointer] loaded into dac_odat_o and dac_refclk_o pulses, counter->0, pointer increments; pointer==LEN wraps to 0 (or, if ONESHOT=1, playback stops and RUN self-clears after last sample). DIV=0: one sample per cycle. First sample appears on dac_odat_o 2 cycles after the RUN write is accepted. LEN=0: sample 0 repeats.
- RUN written 0 mid-playback: next cycle dac_odat_o=0, no further strobes, pointer=0. Writing LEN or DIV during playback takes effect immediately; if pointer already > new LEN it wraps on its next advance.
- Reset mid-playback: all outputs return to reset values at that edge.

Optional Feature:
ASYNC_TRIG_EN: when defined, dac_async_trig_i passes through a 2-flop synchronizer; with TRIG_MODE=1, setting RUN arms (STATUS.bit1=1) and playback starts on the first synchronized rising edge, first sample 2 cycles after that edge is visible post-synchronizer. When not defined, dac_async_trig_i is ignored, CTRL bit2 is unwritable and reads 0, RUN starts playback directly.

Test Plan:
Reset then write 0x001=30 -> up_wack pulses exactly one cycle later, single write; read 0x001 returns 30.
Write RAM 0x800+i = i for i=0..1023 with DACBUF_SIZE=8 -> read 0x805 returns 773 & 0x3FFF (last alias 0x805+0x300), read 0x8FF returns 1023.
Load 0x800+i=i (i=0..255), LEN=30, DIV=0, write CTRL=1 -> dac_odat_o sequence 0,1,...,30,0,1,... with dac_refclk_o high every cycle.
DIV=3, LEN=2 -> strobe every 4 cycles, output 0,1,2,0; ONESHOT=1 -> stops after 2, CTRL reads 0.
Write CTRL=0 during playback -> dac_odat_o=0 next cycle, STATUS.bit0=0.
With ASYNC_TRIG_EN, CTRL=5 -> armed, no output until dac_async_trig_i rises, then sample 0 appears.
